// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a circular FIFO feeding a serializer FSM.
// Frames go out back-to-back with no idle gap while the FIFO has data.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_LOG2    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wEn,
  input  logic [7:0]           dataIn,
  input  logic                 clrErr,
  output logic                 serialOut,
  output logic                 full,
  output logic                 empty,
  output logic [FIFO_LOG2:0]   count,
  output logic                 busy,
  output logic                 overflow
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int CW    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CW-1:0]        BAUD_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]        BAUD_ONE = CW'(1);
  localparam logic [FIFO_LOG2:0]   CNT_FULL = (FIFO_LOG2 + 1)'(DEPTH);
  localparam logic [FIFO_LOG2:0]   CNT_ONE  = (FIFO_LOG2 + 1)'(1);
  localparam logic [FIFO_LOG2-1:0] PTR_ONE  = FIFO_LOG2'(1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [2:0]           bit_q, bit_d;
  logic [7:0]           shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic [FIFO_LOG2-1:0] wr_q, wr_d;
  logic [FIFO_LOG2-1:0] rd_q, rd_d;
  logic [FIFO_LOG2:0]   cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic [7:0]           mem_q [DEPTH];

  logic push;
  logic pop;
  logic last;
  logic is_full;
  logic is_empty;

  assign is_full   = (cnt_q == CNT_FULL);
  assign is_empty  = (cnt_q == '0);
  assign full      = is_full;
  assign empty     = is_empty;
  assign count     = cnt_q;
  assign serialOut = tx_q;
  assign overflow  = ovf_q;
  assign busy      = (state_q != IDLE) || !is_empty;

  assign push = wEn && !is_full;
  assign last = (baud_q == BAUD_MAX);

  always_comb begin
    pop     = 1'b0;
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!is_empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_q];
          baud_d  = '0;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (last) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      DATA: begin
        if (last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      STOP: begin
        if (last) begin
          baud_d = '0;
          // chain straight into the next start bit when more data waits
          if (!is_empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_q];
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    wr_d  = push ? wr_q + PTR_ONE : wr_q;
    rd_d  = pop ? rd_q + PTR_ONE : rd_q;
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
    ovf_d = ovf_q;
    if (wEn && is_full) begin
      ovf_d = 1'b1;
    end else if (clrErr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q] <= dataIn;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: writes push expected bytes into a queue,
// a line monitor decodes frames and compares against it.
module tb_uart_tx_fifo;

  localparam int C  = 4;
  localparam int LG = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wEn = 1'b0;
  logic          clrErr = 1'b0;
  logic [7:0]    dataIn = 8'h00;
  logic          serialOut;
  logic          full;
  logic          empty;
  logic          busy;
  logic          overflow;
  logic [LG:0]   count;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  int frames = 0;

  logic [7:0] expq [$];
  int         starts [$];

  uart_tx_fifo #(
    .CLKS_PER_BIT(C),
    .FIFO_LOG2(LG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wEn(wEn),
    .dataIn(dataIn),
    .clrErr(clrErr),
    .serialOut(serialOut),
    .full(full),
    .empty(empty),
    .count(count),
    .busy(busy),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input bit keep);
    wEn = 1'b1;
    dataIn = b;
    if (keep) expq.push_back(b);
    @(negedge clk);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // line monitor: decodes one frame per falling edge of an idle line
  initial begin
    logic [7:0] got;
    logic       ok;
    logic       ab;
    int         st;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && serialOut === 1'b0) begin
        st = cyc;
        ok = 1'b1;
        ab = 1'b0;
        got = 8'h00;
        for (int i = 1; i < C; i++) begin
          @(negedge clk);
          if (rst !== 1'b1) ab = 1'b1;
          if (serialOut !== 1'b0) ok = 1'b0;
        end
        for (int b = 0; b < 8; b++) begin
          for (int i = 0; i < C; i++) begin
            @(negedge clk);
            if (rst !== 1'b1) ab = 1'b1;
            if (i == 0) got[b] = serialOut;
            else if (serialOut !== got[b]) ok = 1'b0;
          end
        end
        for (int i = 0; i < C; i++) begin
          @(negedge clk);
          if (rst !== 1'b1) ab = 1'b1;
          if (serialOut !== 1'b1) ok = 1'b0;
        end
        if (!ab) begin
          frames++;
          starts.push_back(st);
          chk("frame_shape", {31'd0, ok}, 32'd1);
          if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL frame_unexpected: got %02h expected none", got);
          end else begin
            chk("frame_byte", {24'd0, got}, {24'd0, expq.pop_front()});
          end
        end
      end
    end
  end

  initial begin
    int w;
    int s;
    int nf;
    int peak;
    int low;
    int bad;

    repeat (3) @(negedge clk);
    chk("rst_serial", serialOut, 1);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // single byte 0xA5
    nf = frames;
    w = cyc + 1;
    send(8'hA5, 1'b1);
    wEn = 1'b0;
    chk("single_count", count, 1);
    chk("single_empty", empty, 0);
    s = w + 1;
    wait_cyc(s + 39);
    chk("single_busy_stop", busy, 1);
    chk("single_stop_high", serialOut, 1);
    @(negedge clk);
    chk("single_busy_fall", busy, 0);
    chk("single_frames", frames, nf + 1);
    chk("single_latency", starts[nf], s);

    // burst of three contiguous frames
    nf = frames;
    w = cyc + 1;
    send(8'h01, 1'b1);
    send(8'h02, 1'b1);
    send(8'h03, 1'b1);
    wEn = 1'b0;
    peak = 0;
    repeat (6) begin
      if (int'(count) > peak) peak = int'(count);
      @(negedge clk);
    end
    chk("burst_peak", peak, 2);
    s = w + 1;
    wait_cyc(s + 119);
    chk("burst_busy_end", busy, 1);
    @(negedge clk);
    chk("burst_busy_fall", busy, 0);
    chk("burst_frames", frames, nf + 3);
    chk("burst_start1", starts[nf + 1], s + 10 * C);
    chk("burst_start2", starts[nf + 2], s + 20 * C);

    // overflow: 18 consecutive writes, last one dropped
    nf = frames;
    w = cyc + 1;
    for (int i = 0; i < 18; i++) begin
      if (i == 17) begin
        chk("ovf_full17", full, 1);
        chk("ovf_count17", count, 16);
        chk("ovf_not_yet", overflow, 0);
      end
      send(8'(16 + i), i < 17);
    end
    wEn = 1'b0;
    chk("ovf_flag", overflow, 1);
    chk("ovf_count18", count, 16);
    s = w + 1;
    wait_cyc(s + 17 * 10 * C);
    chk("ovf_drain_busy", busy, 0);
    chk("ovf_drain_count", count, 0);
    chk("ovf_frames", frames, nf + 17);

    // sticky error flag
    chk("sticky_hold", overflow, 1);
    clrErr = 1'b1;
    @(negedge clk);
    clrErr = 1'b0;
    chk("sticky_clear", overflow, 0);
    nf = frames;
    w = cyc + 1;
    for (int i = 0; i < 17; i++) send(8'(64 + i), 1'b1);
    clrErr = 1'b1;
    send(8'hEE, 1'b0);
    clrErr = 1'b0;
    wEn = 1'b0;
    chk("sticky_set_wins", overflow, 1);
    clrErr = 1'b1;
    @(negedge clk);
    clrErr = 1'b0;
    chk("sticky_clear2", overflow, 0);
    s = w + 1;
    wait_cyc(s + 17 * 10 * C);
    chk("sticky_drain_count", count, 0);
    chk("sticky_frames", frames, nf + 17);

    // reset in the middle of data bit 3 of 0x3C
    nf = frames;
    w = cyc + 1;
    send(8'h3C, 1'b0);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    wEn = 1'b0;
    s = w + 1;
    wait_cyc(s + 4 * C + 1);
    chk("mid_bit3", serialOut, 1);
    chk("mid_count", count, 4);
    rst = 1'b0;
    #1;
    chk("mid_rst_serial", serialOut, 1);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (serialOut !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("mid_quiet", bad, 0);
    chk("mid_frames", frames, nf);

    // extremes 0x00 then 0xFF
    nf = frames;
    w = cyc + 1;
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    wEn = 1'b0;
    low = 0;
    for (int i = 0; i < 20 * C; i++) begin
      if (serialOut === 1'b0) low++;
      @(negedge clk);
    end
    chk("ext_low_cycles", low, 10 * C);
    chk("ext_busy", busy, 0);
    chk("ext_count", count, 0);
    chk("ext_empty", empty, 1);
    chk("ext_frames", frames, nf + 2);

    chk("final_queue", expq.size(), 0);
    chk("final_frames", frames, 40);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered 8N1 UART transmitter that drives the board's `serialOut` pin and pairs with the existing `UART_simple` receiver on `serialIn`. It sits in the `clk` domain beside `SerialModule`. `MemoryMap` pushes bytes into it from processor stores, and it serializes them back-to-back at a fixed baud rate. A small FIFO absorbs bursts, so the processor does not stall per byte.

## Interface
Parameters:
- `CLKS_PER_BIT`, 868, `clk` cycles per bit (100 MHz / 115200 baud); must be ≥ 2
- `FIFO_LOG2`, 4, FIFO depth = 2^FIFO_LOG2 entries (16)

Ports:
- `clk`  in  1  system clock; all state changes on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `wEn`  in  1  push `dataIn` into FIFO this cycle
- `dataIn`  in  8  byte to transmit
- `clrErr`  in  1  clear sticky `overflow`
- `serialOut`  out  1  UART line, idle high, registered
- `full`  out  1  FIFO holds 2^FIFO_LOG2 entries
- `empty`  out  1  FIFO holds 0 entries
- `count`  out  FIFO_LOG2+1  current FIFO occupancy
- `busy`  out  1  FSM not in IDLE, or FIFO not empty
- `overflow`  out  1  sticky; a write was dropped because FIFO was full

## Operation
- FIFO: circular buffer, read/write pointers of FIFO_LOG2 bits that wrap modulo depth, separate occupancy counter.
- `full` and `empty` derive from the registered `count`.
- Push: `wEn && !full` writes at the write pointer, pointer +1.
- `wEn && full`: byte dropped, pointers unchanged, `overflow` ← 1. A pop in the same cycle does not rescue the write.
- Same-cycle push and pop: `count` unchanged, both pointers advance.
- `overflow`: set has priority over `clrErr` in the same cycle. Otherwise `clrErr` clears it on the next edge.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `serialOut`=1. If `!empty`: pop the head into the shift register, clear the baud counter, go to START.
  - START: `serialOut`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: `serialOut`=shift[0], LSB first, held CLKS_PER_BIT cycles per bit. Shift right after each bit. After bit 7, go to STOP.
  - STOP: `serialOut`=1 for CLKS_PER_BIT cycles. At its last cycle: if `!empty`, pop and go directly to START (no idle gap); else go to IDLE.
- Baud counter runs 0..CLKS_PER_BIT-1 and wraps to 0 on every bit boundary. Bit index runs 0..7.
- No parity. Exactly one stop bit. Each frame is exactly 10·CLKS_PER_BIT cycles.

## Timing
- Reset value of every output (asserted asynchronously, immediately):
  - `serialOut`=1, `full`=0, `empty`=1, `count`=0, `busy`=0, `overflow`=0
  - FSM=IDLE, pointers=0, counters=0
- Reset mid-frame aborts the frame. Line returns high at once, and FIFO contents are discarded.
- After reset release, nothing transmits until a new write.
- Write at edge k:
  - `count`/`empty` update after edge k.
  - IDLE pops at edge k+1.
  - `serialOut` falls after edge k+1, so latency from write to start bit is 1 cycle.
- Back-to-back frames are contiguous: the next start bit begins the cycle after the last stop-bit cycle.
- `busy` falls the cycle after the final STOP cycle when the FIFO is empty.
- Consecutive writes from empty, starting at edge 1: `count` = n−1 after edge n (n ≥ 2), so the 17th consecutive write fills the 16-entry FIFO.

## Test plan
Benches use CLKS_PER_BIT=4, FIFO_LOG2=4.
- Single byte: reset, write 0xA5 → `serialOut` low 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then high 4 cycles; 40 cycles total; `busy` 0 the cycle after.
- Burst: write 0x01, 0x02, 0x03 on consecutive cycles → three contiguous frames totaling 120 cycles, no high gap between a stop bit and the next start bit; `count` peaks at 2.
- Overflow: write 18 bytes on consecutive cycles → `full`=1 after the 17th; 18th dropped; `overflow`=1; exactly 17 frames transmitted, in order.
- Sticky error:
  - `clrErr` pulse with no write → `overflow` 0 next cycle.
  - `clrErr` coinciding with a dropped write → `overflow` stays 1.
- Reset mid-frame: assert `rst` low during DATA bit 3 of 0x3C with 5 bytes queued → `serialOut`=1 immediately, `count`=0, `empty`=1; no activity after release until a new write.
- Extremes: write 0x00 then 0xFF → frame 1 low for 36 cycles then high 4; frame 2 low 4 then high 36; `count` returns to 0.
